// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared FSM encoding and default widths for the shift scheduler
package shift_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin arbiter
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant    = 2'b00;
        grant[0] = req[0] & (~req[1] | last);
        grant[1] = req[1] & (~req[0] | ~last);
    end

endmodule

// File: rtl/shift_sched.sv
// rtl/shift_sched.sv - shares one shift unit between two requesters with round-robin arbitration
module shift_sched
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_val,
    input  logic [CNT_W-1:0] req0_cnt,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_val,
    input  logic [CNT_W-1:0] req1_cnt,
    output logic             req1_ready,
    output logic             sh_load,
    output logic [WIDTH-1:0] sh_val,
    output logic             sh_en,
    input  logic [WIDTH-1:0] sh_q,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    input  logic             rsp_ready
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    logic             last;
    logic             cap_id;
    logic [CNT_W-1:0] cap_cnt;
    logic [CNT_W-1:0] down;
    logic             first;
    logic [WIDTH-1:0] held;
    logic [1:0]       grant;

    rr_arb2 u_arb (
        .req   ({req1_valid, req0_valid}),
        .last  (last),
        .grant (grant)
    );

    assign req0_ready = (state == S_IDLE) & ~rst & grant[0];
    assign req1_ready = (state == S_IDLE) & ~rst & grant[1];

    // The final shift lands on the same edge that enters DONE, so the first
    // DONE cycle passes sh_q through and later cycles use the held copy.
    always_comb begin
        rsp_data = '0;
        if (rsp_valid) begin
            rsp_data = first ? sh_q : held;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            last      <= 1'b1;
            cap_id    <= 1'b0;
            cap_cnt   <= '0;
            down      <= '0;
            first     <= 1'b0;
            held      <= '0;
            sh_load   <= 1'b0;
            sh_val    <= '0;
            sh_en     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|grant) begin
                        cap_id  <= grant[1];
                        cap_cnt <= grant[1] ? req1_cnt : req0_cnt;
                        sh_val  <= grant[1] ? req1_val : req0_val;
                        sh_load <= 1'b1;
                        state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    sh_load <= 1'b0;
                    if (cap_cnt != '0) begin
                        sh_en <= 1'b1;
                        down  <= cap_cnt;
                        state <= S_SHIFT;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= cap_id;
                        first     <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_SHIFT: begin
                    if (down == CNT_ONE) begin
                        sh_en     <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_id    <= cap_id;
                        first     <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        down <= down - CNT_ONE;
                    end
                end
                S_DONE: begin
                    first <= 1'b0;
                    if (first) begin
                        held <= sh_q;
                    end
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_id    <= 1'b0;
                        last      <= cap_id;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
